// File: rtl/sys_rst_gen.sv
// ---------------------------------------------------------------------------
// sys_rst_gen
//
// Board-level reset pulse generator. It takes the system WDT overtime flag
// and a software reset command written over the MM slave bus. A new trigger
// produces an active-low reset pulse of PW units. A hold-off window of
// HOLDOFF_UNITS units follows, during which further triggers are ignored.
// The cause of the last reset(s) and a saturating reset count are kept in a
// bus-readable status register.
//
// One unit is TICK_DIV cycles of clk_sys_i. The prescaler counts
// 0..TICK_DIV-1, and an 8-bit unit counter advances each time it wraps.
//
// Both outputs are registered from the current state. They therefore follow
// the state by one clock: a trigger sampled at edge N is visible on the pins
// at edge N+1. The pulse and busy widths still equal the number of cycles
// the FSM spends in each state.
// ---------------------------------------------------------------------------
module sys_rst_gen #(
    parameter int          MM_ADDR_WIDTH     = 8,
    parameter int          MM_DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_RST_CTRL = 'h0E,
    parameter int unsigned REG_ADDR_RST_STAT = 'h10,
    parameter int          TICK_DIV          = 1000,
    parameter int          HOLDOFF_UNITS     = 4
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_n_i,
    input  logic [MM_ADDR_WIDTH-1:0] mm_s_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] mm_s_wdata_i,
    output logic [MM_DATA_WIDTH-1:0] mm_s_rdata_o,
    input  logic                     mm_s_we_i,
    input  logic                     wdt_ot_i,
    output logic                     sys_rst_n_o,
    output logic                     rst_busy_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0]       PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [7:0]               HOLD_LAST  = 8'(HOLDOFF_UNITS - 1);
    localparam logic [MM_ADDR_WIDTH-1:0] CTRL_ADDR  = MM_ADDR_WIDTH'(REG_ADDR_RST_CTRL);
    localparam logic [MM_ADDR_WIDTH-1:0] STAT_ADDR  = MM_ADDR_WIDTH'(REG_ADDR_RST_STAT);

    localparam logic [7:0] SOFT_RST_KEY = 8'hC3;
    localparam logic [7:0] PW_RESET     = 8'h10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    // Index of each cause bit in the status register
    localparam int CAUSE_WDT  = 0;
    localparam int CAUSE_SOFT = 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_reg,   state_next;
    logic [PRESC_W-1:0] presc_reg,   presc_next;
    logic [7:0]         unit_reg,    unit_next;
    logic [7:0]         pw_lat_reg,  pw_lat_next;
    logic [7:0]         pw_reg,      pw_next;
    logic [1:0]         cause_reg,   cause_next;
    logic [7:0]         cnt_reg,     cnt_next;
    logic               ot_q_reg;
    logic               sys_rst_n_reg;
    logic               busy_reg;

    // ------------------------------------------------------------------
    // Bus decode and trigger detection
    // ------------------------------------------------------------------
    logic       ctrl_sel;
    logic       stat_sel;
    logic       ctrl_wr;
    logic       stat_wr;
    logic       soft_trig;
    logic       wdt_trig;
    logic       accept;
    logic       tick_wrap;
    logic [7:0] unit_last;
    logic [1:0] cause_set;
    logic [1:0] cause_clr;
    logic [7:0] cnt_base;

    assign ctrl_sel  = (mm_s_addr_i == CTRL_ADDR);
    assign stat_sel  = (mm_s_addr_i == STAT_ADDR);
    assign ctrl_wr   = mm_s_we_i & ctrl_sel;
    assign stat_wr   = mm_s_we_i & stat_sel;

    // Only the exact key requests a soft reset, so a stray CTRL write that
    // merely updates PW can never reset the board.
    assign soft_trig = ctrl_wr & (mm_s_wdata_i[15:8] == SOFT_RST_KEY);

    // Rising edge of the overtime flag. A flag held high fires only once.
    assign wdt_trig  = wdt_ot_i & ~ot_q_reg;

    // Triggers are honoured only in IDLE. Elsewhere they are discarded
    // rather than queued.
    assign accept    = (state_reg == ST_IDLE) & (wdt_trig | soft_trig);

    assign tick_wrap = (presc_reg == PRESC_LAST);

    // The terminal unit depends on the phase: the latched pulse width while
    // asserting, or the fixed hold-off length afterwards.
    assign unit_last = (state_reg == ST_ASSERT) ? (pw_lat_reg - 8'd1) : HOLD_LAST;

    // PW takes the value written this cycle. A combined "C3 + PW" write
    // therefore fires a pulse of the newly written width.
    assign pw_next   = ctrl_wr ? mm_s_wdata_i[7:0] : pw_reg;

    // ------------------------------------------------------------------
    // Cause bits: set on an accepted trigger, W1C from the bus, set wins
    // ------------------------------------------------------------------
    assign cause_set[CAUSE_WDT]  = accept & wdt_trig;
    assign cause_set[CAUSE_SOFT] = accept & soft_trig;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cause
            assign cause_clr[gi]  = stat_wr & mm_s_wdata_i[gi];
            assign cause_next[gi] = cause_set[gi] | (cause_reg[gi] & ~cause_clr[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset counter: clear first, then a saturating increment, so a clear
    // that coincides with a trigger leaves a count of one.
    // ------------------------------------------------------------------
    assign cnt_base = (stat_wr & mm_s_wdata_i[2]) ? 8'h00 : cnt_reg;

    // Next-count selection with saturation at 8'hFF
    always_comb begin
        cnt_next = cnt_base;
        if (accept && (cnt_base != 8'hFF)) begin
            cnt_next = cnt_base + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state with the prescaler and unit counter that time it
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        presc_next  = presc_reg;
        unit_next   = unit_reg;
        pw_lat_next = pw_lat_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next  = ST_ASSERT;
                    // A zero width would never terminate, so it means one unit
                    pw_lat_next = (pw_next == 8'h00) ? 8'h01 : pw_next;
                    presc_next  = '0;
                    unit_next   = 8'h00;
                end
            end

            ST_ASSERT, ST_HOLDOFF: begin
                if (tick_wrap) begin
                    presc_next = '0;
                    if (unit_reg == unit_last) begin
                        unit_next  = 8'h00;
                        state_next = (state_reg == ST_ASSERT) ? ST_HOLDOFF : ST_IDLE;
                    end else begin
                        unit_next = unit_reg + 8'd1;
                    end
                end else begin
                    presc_next = presc_reg + PRESC_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                presc_next = '0;
                unit_next  = 8'h00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register update, with a synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            presc_reg     <= '0;
            unit_reg      <= 8'h00;
            pw_lat_reg    <= 8'h01;
            pw_reg        <= PW_RESET;
            cause_reg     <= 2'b00;
            cnt_reg       <= 8'h00;
            ot_q_reg      <= 1'b0;
            sys_rst_n_reg <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            unit_reg      <= unit_next;
            pw_lat_reg    <= pw_lat_next;
            pw_reg        <= pw_next;
            cause_reg     <= cause_next;
            cnt_reg       <= cnt_next;
            ot_q_reg      <= wdt_ot_i;
            sys_rst_n_reg <= (state_reg != ST_ASSERT);
            busy_reg      <= (state_reg != ST_IDLE);
        end
    end

    assign sys_rst_n_o = sys_rst_n_reg;
    assign rst_busy_o  = busy_reg;

    // ------------------------------------------------------------------
    // Read mux: combinational on address, forced to zero while in reset
    // ------------------------------------------------------------------
    always_comb begin
        mm_s_rdata_o = '0;
        if (rst_n_i) begin
            if (ctrl_sel) begin
                mm_s_rdata_o[7:0] = pw_reg;
            end else if (stat_sel) begin
                mm_s_rdata_o[1:0]  = cause_reg;
                mm_s_rdata_o[15:8] = cnt_reg;
            end
        end
    end

endmodule

// File: tb/tb_sys_rst_gen.sv
// ---------------------------------------------------------------------------
// tb_sys_rst_gen
//
// Scoreboard bench for sys_rst_gen with TICK_DIV=4 and HOLDOFF_UNITS=4.
// The stimulus pushes expected pulse widths, busy widths and register
// values into queues. A monitor on the falling clock edge measures each
// pulse as it ends and samples each requested probe, then compares the
// result against the front of the matching queue.
// ---------------------------------------------------------------------------
module tb_sys_rst_gen;

    localparam int TD = 4;
    localparam int HU = 4;

    localparam logic [7:0] A_CTRL = 8'h0E;
    localparam logic [7:0] A_STAT = 8'h10;

    logic        clk_sys_i = 1'b0;
    logic        rst_n_i   = 1'b0;
    logic [7:0]  mm_s_addr_i  = 8'h00;
    logic [15:0] mm_s_wdata_i = 16'h0000;
    logic [15:0] mm_s_rdata_o;
    logic        mm_s_we_i = 1'b0;
    logic        wdt_ot_i  = 1'b0;
    logic        sys_rst_n_o;
    logic        rst_busy_o;

    always #5 clk_sys_i = ~clk_sys_i;

    sys_rst_gen #(
        .MM_ADDR_WIDTH     (8),
        .MM_DATA_WIDTH     (16),
        .REG_ADDR_RST_CTRL ('h0E),
        .REG_ADDR_RST_STAT ('h10),
        .TICK_DIV          (TD),
        .HOLDOFF_UNITS     (HU)
    ) dut (
        .clk_sys_i    (clk_sys_i),
        .rst_n_i      (rst_n_i),
        .mm_s_addr_i  (mm_s_addr_i),
        .mm_s_wdata_i (mm_s_wdata_i),
        .mm_s_rdata_o (mm_s_rdata_o),
        .mm_s_we_i    (mm_s_we_i),
        .wdt_ot_i     (wdt_ot_i),
        .sys_rst_n_o  (sys_rst_n_o),
        .rst_busy_o   (rst_busy_o)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          kind;   // 0: read data, 1: {busy, sys_rst_n}
        logic [15:0] exp;
        string       name;
    } probe_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     low_q[$];
    int     busy_q[$];
    probe_t probe_q[$];
    logic   probe_req = 1'b0;
    bit     mon_en = 1'b0;
    int     low_cnt = 0;
    int     busy_cnt = 0;

    // Monitor: measures pulses and answers probes on the falling edge
    initial begin
        int          e;
        probe_t      p;
        logic [15:0] act;
        forever begin
            @(negedge clk_sys_i);
            if (mon_en) begin
                if (sys_rst_n_o !== 1'b1) begin
                    low_cnt++;
                end else if (low_cnt != 0) begin
                    n_cmp++;
                    if (low_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL pulse_low: got unexpected pulse of %0d cycles, required none", low_cnt);
                    end else begin
                        e = low_q.pop_front();
                        if (e != low_cnt) begin
                            n_bad++;
                            $display("FAIL pulse_low: got %0d cycles, required %0d", low_cnt, e);
                        end else begin
                            $display("ok   pulse_low %0d cycles", low_cnt);
                        end
                    end
                    low_cnt = 0;
                end

                if (rst_busy_o !== 1'b0) begin
                    busy_cnt++;
                end else if (busy_cnt != 0) begin
                    n_cmp++;
                    if (busy_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL busy_len: got unexpected busy of %0d cycles, required none", busy_cnt);
                    end else begin
                        e = busy_q.pop_front();
                        if (e != busy_cnt) begin
                            n_bad++;
                            $display("FAIL busy_len: got %0d cycles, required %0d", busy_cnt, e);
                        end else begin
                            $display("ok   busy_len %0d cycles", busy_cnt);
                        end
                    end
                    busy_cnt = 0;
                end
            end

            if (probe_req) begin
                n_cmp++;
                if (probe_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL probe: request with empty expectation queue");
                end else begin
                    p   = probe_q.pop_front();
                    act = (p.kind == 0) ? mm_s_rdata_o : {14'h0, rst_busy_o, sys_rst_n_o};
                    if (act !== p.exp) begin
                        n_bad++;
                        $display("FAIL %s: got 16'h%04h, required 16'h%04h", p.name, act, p.exp);
                    end else begin
                        $display("ok   %s = 16'h%04h", p.name, act);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys_i);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [15:0] data);
        mm_s_addr_i  = addr;
        mm_s_wdata_i = data;
        mm_s_we_i    = 1'b1;
        tick(1);
        mm_s_we_i    = 1'b0;
    endtask

    task automatic push_probe(input int kind, input logic [15:0] exp, input string name);
        probe_t p;
        p.kind = kind;
        p.exp  = exp;
        p.name = name;
        probe_q.push_back(p);
        probe_req = 1'b1;
        tick(1);
        probe_req = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [15:0] exp, input string name);
        mm_s_addr_i = addr;
        push_probe(0, exp, name);
    endtask

    task automatic lvl(input logic [15:0] exp, input string name);
        push_probe(1, exp, name);
    endtask

    task automatic expect_pulse(input int lo, input int bz);
        low_q.push_back(lo);
        busy_q.push_back(bz);
    endtask

    // Waits for busy to rise and then fall, with a bound on each wait
    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!rst_busy_o && k < 8) begin
            tick(1);
            k++;
        end
        if (!rst_busy_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_start: busy got 0, required 1 within 8 cycles", name);
        end
        k = 0;
        while (rst_busy_o && k < 2000) begin
            tick(1);
            k++;
        end
        if (rst_busy_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_end: busy got 1, required 0 within 2000 cycles", name);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int k;

        rst_n_i = 1'b0;
        tick(3);
        rst_n_i = 1'b1;
        tick(1);
        mon_en = 1'b1;

        // Reset state
        lvl(16'h0001, "reset_levels");
        rd(A_CTRL, 16'h0010, "reset_ctrl");
        rd(A_STAT, 16'h0000, "reset_stat");

        // WDT trigger with PW=3: 12 low, 28 busy
        wr(A_CTRL, 16'h0003);
        expect_pulse(12, 28);
        wdt_ot_i = 1'b1;
        tick(3);
        wdt_ot_i = 1'b0;
        wait_idle("wdt_pw3");
        rd(A_STAT, 16'h0101, "stat_after_wdt");

        // Soft reset with PW=5 in the same write: 20 low, 36 busy
        expect_pulse(20, 36);
        wr(A_CTRL, 16'hC305);
        wait_idle("soft_pw5");
        rd(A_STAT, 16'h0203, "stat_after_soft");
        rd(A_CTRL, 16'h0005, "ctrl_cmd_reads_0");

        // Wrong key: PW updates, but no pulse
        wr(A_CTRL, 16'hC2AA);
        tick(10);
        lvl(16'h0001, "no_pulse_bad_key");
        rd(A_CTRL, 16'h00AA, "ctrl_after_bad_key");

        // WDT held high, with a soft command issued during HOLDOFF
        wr(A_STAT, 16'h0007);
        rd(A_STAT, 16'h0000, "stat_cleared");
        wr(A_CTRL, 16'h0002);
        expect_pulse(8, 24);
        wdt_ot_i = 1'b1;
        tick(12);
        wr(A_CTRL, 16'hC302);
        tick(87);
        wdt_ot_i = 1'b0;
        rd(A_STAT, 16'h0101, "stat_held_ot");
        tick(2);
        expect_pulse(8, 24);
        wdt_ot_i = 1'b1;
        tick(1);
        wait_idle("ot_retrigger");
        wdt_ot_i = 1'b0;
        rd(A_STAT, 16'h0201, "stat_retrigger");

        // PW=0 means one unit; a PW write mid-pulse applies to the next one
        wr(A_CTRL, 16'h0000);
        expect_pulse(4, 20);
        wdt_ot_i = 1'b1;
        tick(2);
        wr(A_CTRL, 16'h0008);
        wdt_ot_i = 1'b0;
        wait_idle("pw0");
        rd(A_CTRL, 16'h0008, "ctrl_pw8");
        expect_pulse(32, 48);
        wdt_ot_i = 1'b1;
        tick(1);
        wdt_ot_i = 1'b0;
        wait_idle("pw8");

        // Simultaneous WDT and soft triggers
        wr(A_STAT, 16'h0007);
        wr(A_CTRL, 16'h0001);
        expect_pulse(4, 20);
        wdt_ot_i = 1'b1;
        wr(A_CTRL, 16'hC301);
        wdt_ot_i = 1'b0;
        wait_idle("both_trig");
        rd(A_STAT, 16'h0103, "stat_both_causes");
        wr(A_STAT, 16'h0001);
        rd(A_STAT, 16'h0102, "stat_w1c_wdt");
        wr(A_STAT, 16'h0004);
        rd(A_STAT, 16'h0002, "stat_cnt_clear");

        // Set beats W1C, and a count clear with an increment gives 1
        expect_pulse(4, 20);
        wdt_ot_i = 1'b1;
        wr(A_STAT, 16'h0007);
        wdt_ot_i = 1'b0;
        wait_idle("set_vs_clear");
        rd(A_STAT, 16'h0101, "stat_set_wins");

        // Reset asserted at pulse cycle 5
        wr(A_CTRL, 16'h0003);
        expect_pulse(5, 5);
        wr(A_CTRL, 16'hC303);
        k = 0;
        while (sys_rst_n_o && k < 8) begin
            tick(1);
            k++;
        end
        if (sys_rst_n_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL abort_start: sys_rst_n got 1, required 0 within 8 cycles");
        end
        tick(4);
        rst_n_i = 1'b0;
        rd(A_CTRL, 16'h0000, "rdata_in_reset");
        lvl(16'h0001, "levels_after_reset");
        rst_n_i = 1'b1;
        tick(1);
        rd(A_CTRL, 16'h0010, "ctrl_after_reset");
        rd(A_STAT, 16'h0000, "stat_after_reset");

        // Count saturation at 8'hFF
        for (int i = 0; i < 255; i++) begin
            expect_pulse(4, 20);
            wr(A_CTRL, 16'hC301);
            wait_idle("sat");
        end
        rd(A_STAT, 16'hFF02, "stat_cnt_255");
        expect_pulse(4, 20);
        wr(A_CTRL, 16'hC301);
        wait_idle("sat_last");
        rd(A_STAT, 16'hFF02, "stat_cnt_saturated");

        // Every expected pulse and probe must have been consumed
        tick(30);
        n_cmp++;
        if (low_q.size() != 0 || busy_q.size() != 0 || probe_q.size() != 0) begin
            n_bad++;
            $display("FAIL queues_drained: got %0d/%0d/%0d entries left, required 0/0/0",
                     low_q.size(), busy_q.size(), probe_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
